// File: rtl/ram_bus_bridge.sv
// Valid/ready byte-addressed bus front end for a 1-cycle synchronous word RAM, with
// read-modify-write for partial stores. Optional macro RAM_BRIDGE_STATS_EN adds response counters.
//
// state   | meaning
// IDLE    | ready for a request
// RD_WAIT | RAM samples the word address
// RD_CAP  | ram_dout valid: capture read data or build the merged write word
// WR      | RAM commits the write on this edge
// RESP    | response held until the consumer takes it
module ram_bus_bridge #(
   parameter int          MEM_SIZE_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter int          ADDR_W         = $clog2(MEM_SIZE_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic              req_we,
   input  logic [3:0]        req_be,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
`ifdef RAM_BRIDGE_STATS_EN
   ,
   output logic [15:0]       stat_rd_cnt,
   output logic [15:0]       stat_wr_cnt,
   output logic [15:0]       stat_err_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR, RESP} state_t;

   localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_SIZE_WORDS);

   state_t              state_q, state_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [31:0]         ram_din_q, ram_din_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdata_q, wdata_d;

   logic [31:0]         off;
   logic                acc_err;
   logic [31:0]         merged;

   assign req_ready = (state_q == IDLE) && !rst;
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;

   // Offset wraps at 32 bits; the explicit below-base test catches the wrapped case.
   assign off     = req_addr - BASE_ADDR;
   assign acc_err = (req_addr < BASE_ADDR) || ({1'b0, off} >= MEM_BYTES) || (off[1:0] != 2'b00);

   always_comb begin
      merged = ram_dout;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_din_d   = ram_din_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      we_d        = we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               be_d    = req_be;
               wdata_d = req_wdata;
               if (acc_err) begin
                  rsp_err_d = 1'b1;
                  state_d   = RESP;
               end else if (req_we && (req_be == 4'h0)) begin
                  state_d = RESP;
               end else if (req_we && (req_be == 4'hF)) begin
                  ram_addr_d = off[ADDR_W+1:2];
                  ram_din_d  = req_wdata;
                  ram_we_d   = 1'b1;
                  state_d    = WR;
               end else begin
                  ram_addr_d = off[ADDR_W+1:2];
                  ram_we_d   = 1'b0;
                  state_d    = RD_WAIT;
               end
            end
         end
         RD_WAIT: state_d = RD_CAP;
         RD_CAP: begin
            if (we_q) begin
               ram_din_d = merged;
               ram_we_d  = 1'b1;
               state_d   = WR;
            end else begin
               rsp_rdata_d = ram_dout;
               state_d     = RESP;
            end
         end
         WR: begin
            ram_we_d = 1'b0;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= 32'h0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= 4'h0;
         wdata_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
      end
   end

`ifdef RAM_BRIDGE_STATS_EN
   logic [15:0] stat_rd_q, stat_wr_q, stat_err_q;
   logic        rsp_hs;

   assign rsp_hs       = (state_q == RESP) && rsp_ready;
   assign stat_rd_cnt  = stat_rd_q;
   assign stat_wr_cnt  = stat_wr_q;
   assign stat_err_cnt = stat_err_q;

   // Counters saturate rather than wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_rd_q  <= 16'h0;
         stat_wr_q  <= 16'h0;
         stat_err_q <= 16'h0;
      end else if (rsp_hs) begin
         if (rsp_err_q) begin
            if (stat_err_q != 16'hFFFF) stat_err_q <= stat_err_q + 16'd1;
         end else if (we_q) begin
            if (stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
         end else begin
            if (stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Scoreboard bench for ram_bus_bridge: directed requests push expected responses, a negedge
// monitor pops and checks data, error flag, latency, hold stability and RAM write pulses.
module tb_ram_bus_bridge;
   localparam int MEM_W = 4096;
   localparam int AW    = $clog2(MEM_W);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_addr = 32'h0;
   logic          req_we = 1'b0;
   logic [3:0]    req_be = 4'h0;
   logic [31:0]   req_wdata = 32'h0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout = 32'h0;
`ifdef RAM_BRIDGE_STATS_EN
   logic [15:0]   stat_rd_cnt, stat_wr_cnt, stat_err_cnt;
`endif

   ram_bus_bridge #(.MEM_SIZE_WORDS(MEM_W), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
      .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_BRIDGE_STATS_EN
      , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_err_cnt(stat_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:MEM_W-1] = '{default: 32'h0};
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [31:0] rd; logic err; int lat; int acc; } exp_t;
   exp_t        sb[$];
   exp_t        e;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          stall_left = 0;
   bit          in_rsp = 0;
   int          hs_cyc = 0;
   int          last_acc = 0;
   int          we_pulses = 0;
   int          base;
   logic [AW-1:0] we_addr = '0;
   logic        prev_we = 1'b0;
   logic [31:0] first_rd = 32'h0;
   logic        first_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: checks responses against the scoreboard and applies response backpressure.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         in_rsp    = 0;
         prev_we   = 1'b0;
         rsp_ready = 1'b1;
      end else begin
         if (ram_we) begin
            check("ram_we_single_cycle", 32'(prev_we), 32'h0);
            we_pulses++;
            we_addr = ram_addr;
         end
         prev_we = ram_we;
         if (rsp_valid && !in_rsp) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_rsp: got rdata %h err %0d with no request pending", rsp_rdata, rsp_err);
            end else begin
               e = sb.pop_front();
               check("rsp_rdata", rsp_rdata, e.rd);
               check("rsp_err", 32'(rsp_err), 32'(e.err));
               check("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
            first_rd  = rsp_rdata;
            first_err = rsp_err;
            in_rsp    = 1;
         end else if (rsp_valid && in_rsp) begin
            check("hold_rdata", rsp_rdata, first_rd);
            check("hold_err", 32'(rsp_err), 32'(first_err));
            check("hold_req_ready", 32'(req_ready), 32'h0);
         end else if (!rsp_valid && in_rsp) begin
            in_rsp = 0;
            hs_cyc = cyc;
            check("post_hs_rdata", rsp_rdata, 32'h0);
            check("post_hs_err", 32'(rsp_err), 32'h0);
         end
         if (rsp_valid && stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
         end else begin
            rsp_ready = 1'b1;
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int elat, input bit push);
      int   n = 0;
      exp_t it;
      @(negedge clk);
      req_addr  = a;
      req_we    = w;
      req_be    = b;
      req_wdata = wd;
      req_valid = 1'b1;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("req_accept_in_time", 32'(n < 100), 32'h1);
      it.rd  = erd;
      it.err = eerr;
      it.lat = elat;
      it.acc = cyc + 1;
      last_acc = it.acc;
      if (push) sb.push_back(it);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || in_rsp || !req_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_in_time", 32'(n < 200), 32'h1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
      check({tag, "_ram_we"}, 32'(ram_we), 32'h0);
      check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
      check({tag, "_ram_din"}, ram_din, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      #12;
      check_reset_outputs("por");
      @(negedge clk);
      rst = 1'b0;

      // Full write then read of word 4
      base = we_pulses;
      issue(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
      wait_idle();
      check("full_wr_pulses", 32'(we_pulses - base), 32'h1);
      check("full_wr_addr", 32'(we_addr), 32'h4);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);

      // Partial writes (read-modify-write)
      issue(32'h10, 1'b1, 4'b0101, 32'h11223344, 32'h0, 1'b0, 4, 1'b1);
      issue(32'h10, 1'b0, 4'h0, 32'h0, 32'hDE22BE44, 1'b0, 3, 1'b1);
      issue(32'h20, 1'b1, 4'hF, 32'h01020304, 32'h0, 1'b0, 2, 1'b1);
      issue(32'h20, 1'b1, 4'b1000, 32'hAABBCCDD, 32'h0, 1'b0, 4, 1'b1);
      issue(32'h20, 1'b0, 4'hF, 32'h0, 32'hAA020304, 1'b0, 3, 1'b1);
      wait_idle();

      // Write with no byte enables touches nothing
      base = we_pulses;
      issue(32'h10, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1, 1'b1);
      wait_idle();
      check("be0_no_ram_we", 32'(we_pulses - base), 32'h0);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDE22BE44, 1'b0, 3, 1'b1);
      wait_idle();

      // Misaligned, one past the end, and far out of range
      base = we_pulses;
      issue(32'h12, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      issue(32'h4000, 1'b1, 4'hF, 32'h12345678, 32'h0, 1'b1, 1, 1'b1);
      issue(32'hFFFFFFFC, 1'b1, 4'b0011, 32'h12345678, 32'h0, 1'b1, 1, 1'b1);
      wait_idle();
      check("err_no_ram_we", 32'(we_pulses - base), 32'h0);

      // Last word in range
      issue(32'h3FFC, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
      wait_idle();
      check("last_word_addr", 32'(we_addr), 32'hFFF);
      issue(32'h3FFC, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1);
      wait_idle();

      // Response backpressure, then back-to-back request
      stall_left = 5;
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDE22BE44, 1'b0, 3, 1'b1);
      issue(32'h20, 1'b0, 4'hF, 32'h0, 32'hAA020304, 1'b0, 3, 1'b1);
      check("accept_after_hs", 32'(last_acc), 32'(hs_cyc + 1));
      wait_idle();

      // Reset in the middle of a partial write
      issue(32'h30, 1'b1, 4'hF, 32'h55667788, 32'h0, 1'b0, 2, 1'b1);
      wait_idle();
      base = we_pulses;
      issue(32'h30, 1'b1, 4'b0011, 32'hFFFFFFFF, 32'h0, 1'b0, 4, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_no_ram_we", 32'(we_pulses - base), 32'h0);
      issue(32'h30, 1'b0, 4'hF, 32'h0, 32'h55667788, 1'b0, 3, 1'b1);
      wait_idle();

`ifdef RAM_BRIDGE_STATS_EN
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("stat_rd_rst", 32'(stat_rd_cnt), 32'h0);
      check("stat_wr_rst", 32'(stat_wr_cnt), 32'h0);
      check("stat_err_rst", 32'(stat_err_cnt), 32'h0);
      issue(32'h10, 1'b0, 4'hF, 32'h0, 32'hDE22BE44, 1'b0, 3, 1'b1);
      issue(32'h20, 1'b0, 4'hF, 32'h0, 32'hAA020304, 1'b0, 3, 1'b1);
      issue(32'h30, 1'b0, 4'hF, 32'h0, 32'h55667788, 1'b0, 3, 1'b1);
      issue(32'h40, 1'b1, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, 2, 1'b1);
      issue(32'h44, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1, 1'b1);
      issue(32'h13, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      wait_idle();
      check("stat_rd", 32'(stat_rd_cnt), 32'h3);
      check("stat_wr", 32'(stat_wr_cnt), 32'h2);
      check("stat_err", 32'(stat_err_cnt), 32'h1);
      force dut.stat_rd_q = 16'hFFFF;
      @(negedge clk);
      release dut.stat_rd_q;
      issue(32'h40, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, 3, 1'b1);
      wait_idle();
      check("stat_rd_saturate", 32'(stat_rd_cnt), 32'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
